// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges always-accepted load results with buffered ALU
// results onto one register-file write port, with kill-on-collision and
// forwarding lookup over the ALU FIFO and the writeback register.
module wb_arbiter #(
   parameter int ALU_FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [3:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        wb_we,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   input  logic [3:0]  fwd_rs1,
   input  logic [3:0]  fwd_rs2,
   output logic        fwd_rs1_hit,
   output logic        fwd_rs2_hit,
   output logic [31:0] fwd_rs1_data,
   output logic [31:0] fwd_rs2_data,
   input  logic        flush
);
   localparam int D  = ALU_FIFO_DEPTH;
   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = $clog2(D + 1);
   localparam logic [CW-1:0] LP_D = CW'(D);

   logic [3:0]    r_rd   [D];
   logic [31:0]   r_data [D];
   logic          r_v    [D];
   logic [PW-1:0] r_rptr, r_wptr;
   logic [CW-1:0] r_cnt;
   logic          r_we;
   logic [3:0]    r_wb_rd;
   logic [31:0]   r_wb_data;

   logic          w_acc, w_push, w_pop, w_sel, w_we;
   logic [3:0]    w_rd;
   logic [31:0]   w_dat;
   logic [32:0]   w_f1, w_f2;

   // Pointer advance with wrap at the (possibly non power-of-two) depth.
   function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + PW'(1);
   endfunction

   // Forwarding lookup: wb register lowest priority, then FIFO entries
   // oldest->youngest so the youngest matching valid entry overrides.
   function automatic logic [32:0] f_lookup(input logic [3:0] rs);
      logic [32:0] res;
      int          idx;
      res = '0;
      if (r_we && r_wb_rd == rs) res = {1'b1, r_wb_data};
      for (int k = D - 1; k >= 0; k--) begin
         if (k < int'(r_cnt)) begin
            idx = (int'(r_wptr) + D - 1 - k) % D;
            if (r_v[PW'(idx)] && r_rd[PW'(idx)] == rs) res = {1'b1, r_data[PW'(idx)]};
         end
      end
      if (rs == 4'd0) res = '0;
      return res;
   endfunction

   assign alu_ready = (r_cnt < LP_D);
   assign w_acc     = alu_valid && alu_ready && !flush;
   assign w_push    = w_acc && (mem_valid || r_cnt != '0);
   assign w_pop     = !mem_valid && r_cnt != '0 && !flush;

   // Source select: load > FIFO head > ALU bypass; rd==0 or killed never writes.
   always_comb begin
      w_sel = 1'b0;
      w_we  = 1'b0;
      w_rd  = '0;
      w_dat = '0;
      if (mem_valid) begin
         w_sel = 1'b1;
         w_rd  = mem_rd;
         w_dat = mem_data;
         w_we  = (mem_rd != 4'd0);
      end else if (w_pop) begin
         w_sel = 1'b1;
         w_rd  = r_rd[r_rptr];
         w_dat = r_data[r_rptr];
         w_we  = r_v[r_rptr] && (r_rd[r_rptr] != 4'd0);
      end else if (w_acc) begin
         w_sel = 1'b1;
         w_rd  = alu_rd;
         w_dat = alu_data;
         w_we  = (alu_rd != 4'd0);
      end
   end

   // Writeback register; rd/data hold when nothing was selected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we      <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         r_we <= w_we;
         if (w_sel) begin
            r_wb_rd   <= w_rd;
            r_wb_data <= w_dat;
         end
      end
   end

   // ALU FIFO: flush clears, loads kill colliding entries, push lands after kill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_rptr <= '0;
         r_wptr <= '0;
         for (int i = 0; i < D; i++) begin
            r_v[i]    <= 1'b0;
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
      end else if (flush) begin
         r_cnt  <= '0;
         r_rptr <= '0;
         r_wptr <= '0;
         for (int i = 0; i < D; i++) r_v[i] <= 1'b0;
      end else begin
         if (mem_valid && mem_rd != 4'd0)
            for (int i = 0; i < D; i++)
               if (r_rd[i] == mem_rd) r_v[i] <= 1'b0;
         if (w_push) begin
            r_v[r_wptr]    <= 1'b1;
            r_rd[r_wptr]   <= alu_rd;
            r_data[r_wptr] <= alu_data;
            r_wptr         <= f_nxt(r_wptr);
         end
         if (w_pop) r_rptr <= f_nxt(r_rptr);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   assign w_f1         = f_lookup(fwd_rs1);
   assign w_f2         = f_lookup(fwd_rs2);
   assign fwd_rs1_hit  = w_f1[32];
   assign fwd_rs1_data = w_f1[31:0];
   assign fwd_rs2_hit  = w_f2[32];
   assign fwd_rs2_data = w_f2[31:0];
   assign wb_we        = r_we;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences for kill/rd0/
// mid-operation reset, then random traffic against a queue-based model.
module tb_wb_arbiter;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid, flush;
   logic [3:0]  mem_rd, alu_rd, fwd_rs1, fwd_rs2;
   logic [31:0] mem_data, alu_data;
   logic        alu_ready, wb_we, fwd_rs1_hit, fwd_rs2_hit;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data, fwd_rs1_data, fwd_rs2_data;

   wb_arbiter #(.ALU_FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
      .flush(flush)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-order list of pending ALU results plus the wb register.
   typedef struct { logic [3:0] rd; logic [31:0] d; bit v; } ent_t;
   ent_t        q[$];
   bit          m_we;
   logic [3:0]  m_rd;
   logic [31:0] m_d;

   task automatic m_reset();
      q.delete();
      m_we = 0; m_rd = 0; m_d = 0;
   endtask

   function automatic bit m_ready();
      return q.size() < D;
   endfunction

   task automatic m_fwd(input logic [3:0] rs, output bit hit, output logic [31:0] d);
      hit = 0; d = 0;
      if (rs == 0) return;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].v && q[i].rd == rs) begin hit = 1; d = q[i].d; return; end
      if (m_we && m_rd == rs) begin hit = 1; d = m_d; end
   endtask

   task automatic m_next(input bit mv, input logic [3:0] mrd, input logic [31:0] mdat,
                         input bit av, input logic [3:0] ard, input logic [31:0] adat, input bit fl);
      bit   acc;
      ent_t e;
      acc = av && m_ready() && !fl;
      if (mv) begin
         m_we = (mrd != 0); m_rd = mrd; m_d = mdat;
         foreach (q[i]) if (mrd != 0 && q[i].rd == mrd) q[i].v = 0;
         if (acc) q.push_back('{ard, adat, 1'b1});
      end else if (q.size() != 0 && !fl) begin
         e = q.pop_front();
         m_we = e.v && e.rd != 0; m_rd = e.rd; m_d = e.d;
         if (acc) q.push_back('{ard, adat, 1'b1});
      end else if (acc) begin
         m_we = (ard != 0); m_rd = ard; m_d = adat;
      end else begin
         m_we = 0;
      end
      if (fl) q.delete();
   endtask

   bit s_rdy;

   // One cycle: drive at posedge+1, check combinational outputs mid-cycle,
   // check registered outputs just after the next rising edge.
   task automatic step(input bit mv, input logic [3:0] mrd, input logic [31:0] mdat,
                       input bit av, input logic [3:0] ard, input logic [31:0] adat,
                       input bit fl, input logic [3:0] r1, input logic [3:0] r2, input bit r);
      bit          h;
      logic [31:0] d;
      mem_valid = mv; mem_rd = mrd; mem_data = mdat;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      flush = fl; fwd_rs1 = r1; fwd_rs2 = r2; rst = r;
      if (r) m_reset();
      #4;
      s_rdy = alu_ready;
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_ready()});
      chk("wb_we_mid", {31'd0, wb_we}, {31'd0, m_we});
      m_fwd(r1, h, d);
      chk("fwd1_hit", {31'd0, fwd_rs1_hit}, {31'd0, h});
      chk("fwd1_data", fwd_rs1_data, d);
      m_fwd(r2, h, d);
      chk("fwd2_hit", {31'd0, fwd_rs2_hit}, {31'd0, h});
      chk("fwd2_data", fwd_rs2_data, d);
      if (!r) m_next(mv, mrd, mdat, av, ard, adat, fl);
      @(posedge clk); #1;
      chk("wb_we", {31'd0, wb_we}, {31'd0, m_we});
      chk("wb_rd", {28'd0, wb_rd}, {28'd0, m_rd});
      chk("wb_data", wb_data, m_d);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit mv; logic [3:0] mrd; logic [31:0] mdat;
      bit av; logic [3:0] ard; logic [31:0] adat; bit fl;
      bit e_we; logic [3:0] e_rd; logic [31:0] e_d; bit e_rdy;
   } vec_t;
   vec_t tbl[12];

   initial begin
      bit          h;
      logic [31:0] d;
      // single bypass
      tbl[0]  = '{0, 0, 0,       1, 5, 32'h11, 0,  1, 5, 32'h11, 1};
      // load + ALU together, ALU follows next cycle
      tbl[1]  = '{1, 3, 32'hAA,  1, 4, 32'hBB, 0,  1, 3, 32'hAA, 1};
      tbl[2]  = '{0, 0, 0,       0, 0, 0,      0,  1, 4, 32'hBB, 1};
      tbl[3]  = '{0, 0, 0,       0, 0, 0,      0,  0, 4, 32'hBB, 1};
      // load held 3 cycles, ALU every cycle: fill, stall, drain in order
      tbl[4]  = '{1, 1, 32'hA1, 1, 8, 32'h80, 0,   1, 1, 32'hA1, 1};
      tbl[5]  = '{1, 2, 32'hA2, 1, 9, 32'h90, 0,   1, 2, 32'hA2, 1};
      tbl[6]  = '{1, 3, 32'hA3, 1, 10, 32'hA0, 0,  1, 3, 32'hA3, 0};
      tbl[7]  = '{0, 0, 0,      1, 10, 32'hA0, 0,  1, 8, 32'h80, 0};
      tbl[8]  = '{0, 0, 0,      1, 10, 32'hA0, 0,  1, 9, 32'h90, 1};
      tbl[9]  = '{0, 0, 0,      0, 0, 0, 0,        1, 10, 32'hA0, 1};
      tbl[10] = '{0, 0, 0,      0, 0, 0, 0,        0, 10, 32'hA0, 1};
      // rd==0 is consumed without a write
      tbl[11] = '{0, 0, 0,      1, 0, 32'hFF, 0,   0, 0, 32'hFF, 1};

      mem_valid = 0; mem_rd = 0; mem_data = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
      flush = 0; fwd_rs1 = 0; fwd_rs2 = 0; rst = 1;
      m_reset();
      #2;
      chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].mv, tbl[i].mrd, tbl[i].mdat, tbl[i].av, tbl[i].ard, tbl[i].adat,
              tbl[i].fl, 0, 0, 0);
         chk($sformatf("tbl%0d_rdy", i), {31'd0, s_rdy}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("tbl%0d_we", i), {31'd0, wb_we}, {31'd0, tbl[i].e_we});
         if (tbl[i].e_we) begin
            chk($sformatf("tbl%0d_rd", i), {28'd0, wb_rd}, {28'd0, tbl[i].e_rd});
            chk($sformatf("tbl%0d_data", i), wb_data, tbl[i].e_d);
         end
      end

      // rs==0 never hits even though x0 was the last selected destination
      fwd_rs1 = 0; #1;
      chk("fwd_rs0_hit", {31'd0, fwd_rs1_hit}, 32'd0);
      chk("fwd_rs0_data", fwd_rs1_data, 32'd0);

      // kill: FIFO holds x7=1, load x7=2 arrives
      step(1, 2, 32'h5, 1, 7, 32'h1, 0, 7, 0, 0);
      step(1, 7, 32'h2, 0, 0, 0, 0, 7, 0, 0);
      chk("kill_wb_rd", {28'd0, wb_rd}, 32'd7);
      chk("kill_wb_data", wb_data, 32'h2);
      #1;
      chk("kill_fwd_hit", {31'd0, fwd_rs1_hit}, 32'd1);
      chk("kill_fwd_data", fwd_rs1_data, 32'h2);
      step(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
      chk("kill_pop_we", {31'd0, wb_we}, 32'd0);
      idle();

      // flush with queued entries and no load
      step(1, 1, 32'h10, 1, 6, 32'h60, 0, 6, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
      chk("flush_we", {31'd0, wb_we}, 32'd0);
      idle();

      // mid-operation reset with two queued entries
      step(1, 1, 32'h21, 1, 11, 32'hB1, 0, 0, 0, 0);
      step(1, 2, 32'h22, 1, 12, 32'hB2, 0, 0, 0, 0);
      #2;
      rst = 1;
      #1;
      m_reset();
      chk("mrst_wb_we", {31'd0, wb_we}, 32'd0);
      chk("mrst_alu_ready", {31'd0, alu_ready}, 32'd1);
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 0, 11, 12, 1);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("mrst_nowrite", {31'd0, wb_we}, 32'd0);
      end

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 3) == 0, 4'($urandom % 8), $urandom,
              ($urandom % 4) != 0, 4'($urandom % 8), $urandom,
              ($urandom % 20) == 0, 4'($urandom % 8), 4'($urandom % 8),
              ($urandom % 400) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
